// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction RAM slave for the imem valid/ready fetch interface
// Define IMEM_RESPONDER_ERR_EN to add imem_resp_err for out-of-range or misaligned fetches.
module imem_responder #(
  parameter int DEPTH_WORDS     = 256,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           imem_req_valid,
  input  logic [31:0]                    imem_req_addr,
  output logic                           imem_req_ready,
  output logic                           imem_resp_valid,
  output logic [31:0]                    imem_resp_data,
`ifdef IMEM_RESPONDER_ERR_EN
  output logic                           imem_resp_err,
`endif
  input  logic                           imem_resp_ready,
  input  logic                           load_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]    WAIT_INIT = 3'(LATENCY - 1);
  localparam logic [31:0]   NOP_WORD  = 32'h00000013;

  logic [31:0]   mem       [DEPTH_WORDS];
  logic [31:0]   slot_data [MAX_OUTSTANDING];
  logic          slot_err  [MAX_OUTSTANDING];
  logic [2:0]    slot_wait [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          in_reset;

  logic [AW-1:0] req_idx;
  logic          req_oor;
  logic [31:0]   rd_word;
  logic          rd_err;
  logic          head_ready;
  logic          req_fire;
  logic          resp_fire;

  assign req_idx = imem_req_addr[AW+1:2];
  assign req_oor = |imem_req_addr[31:AW+2];

  always_comb begin
    rd_word = mem[req_idx];
    rd_err  = 1'b0;
`ifdef IMEM_RESPONDER_ERR_EN
    if (req_oor || (imem_req_addr[1:0] != 2'b00)) begin
      rd_word = '0;
      rd_err  = 1'b1;
    end
`else
    if (req_oor) begin
      rd_word = NOP_WORD;
    end
`endif
  end

  // in_reset keeps req_ready low for the whole reset window without a path from the reset pin.
  assign imem_req_ready  = !in_reset && (count < MAX_CNT);
  assign head_ready      = (count != '0) && (slot_wait[rd_ptr] == 3'd0);
  assign imem_resp_valid = !in_reset && head_ready;
  assign imem_resp_data  = in_reset ? 32'h0 : slot_data[rd_ptr];
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign resp_fire       = imem_resp_valid && imem_resp_ready;

`ifdef IMEM_RESPONDER_ERR_EN
  assign imem_resp_err = !in_reset && head_ready && slot_err[rd_ptr];
`else
  logic unused_bits;
  assign unused_bits = slot_err[rd_ptr] ^ (^imem_req_addr[1:0]);
`endif

  // RAM and captured read data are never reset; the read uses the pre-load value.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
    if (req_fire) begin
      slot_data[wr_ptr] <= rd_word;
      slot_err[wr_ptr]  <= rd_err;
    end
  end

  always_ff @(posedge clk) begin
    in_reset <= reset;
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        slot_wait[i] <= '0;
      end
    end else begin
      // Every slot keeps aging, including ones queued behind a stalled head.
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (slot_wait[i] != 3'd0) begin
          slot_wait[i] <= slot_wait[i] - 3'd1;
        end
      end
      if (req_fire) begin
        slot_wait[wr_ptr] <= WAIT_INIT;
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (resp_fire) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      end
      case ({req_fire, resp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder (LATENCY 1 and 3 instances)
// Honours IMEM_RESPONDER_ERR_EN when the design is built with it.
module tb_imem_responder;

  localparam logic [32:0] W0 = {1'b0, 32'h00100093};
  localparam logic [32:0] W1 = {1'b0, 32'h00200113};
  localparam logic [32:0] W2 = {1'b0, 32'h002081B3};
  localparam logic [32:0] W3 = {1'b0, 32'h00000013};
  localparam logic [32:0] WL = {1'b0, 32'hCAFEF00D};
  localparam logic [32:0] WD = {1'b0, 32'hDEADBEEF};
`ifdef IMEM_RESPONDER_ERR_EN
  localparam logic [32:0] E_OOR = {1'b1, 32'h0};
  localparam logic [32:0] E_MIS = {1'b1, 32'h0};
`else
  localparam logic [32:0] E_OOR = {1'b0, 32'h00000013};
  localparam logic [32:0] E_MIS = W1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        req_valid  [2];
  logic [31:0] req_addr   [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_data  [2];
  logic        resp_ready [2];
`ifdef IMEM_RESPONDER_ERR_EN
  logic        resp_err   [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_fire [2];
  int last_fire [2];
  logic        hold_pending [2];
  logic [32:0] hold_val [2];
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY((g == 0) ? 1 : 3),
      .MAX_OUTSTANDING(2)
    ) u_dut (
      .clk(clk),
      .reset(rst),
      .imem_req_valid(req_valid[g]),
      .imem_req_addr(req_addr[g]),
      .imem_req_ready(req_ready[g]),
      .imem_resp_valid(resp_valid[g]),
      .imem_resp_data(resp_data[g]),
`ifdef IMEM_RESPONDER_ERR_EN
      .imem_resp_err(resp_err[g]),
`endif
      .imem_resp_ready(resp_ready[g]),
      .load_we(load_we),
      .load_addr(load_addr),
      .load_data(load_data)
    );
  end

  function automatic void chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void on_fire(input int d, input logic [32:0] got);
    logic [32:0] e;
    n_fire[d]++;
    last_fire[d] = cyc;
    if (qsize(d) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_resp dut%0d: got %h expected none", d, got);
      return;
    end
    if (d == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    chk($sformatf("resp_dut%0d", d), got, e);
  endfunction

  // Monitor: scoreboard pops on every response handshake and checks backpressure stability.
  initial begin
    logic [32:0] got;
    for (int d = 0; d < 2; d++) begin
      n_fire[d] = 0;
      last_fire[d] = 0;
      hold_pending[d] = 1'b0;
      hold_val[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
`ifdef IMEM_RESPONDER_ERR_EN
        got = {resp_err[d], resp_data[d]};
`else
        got = {1'b0, resp_data[d]};
`endif
        if (hold_pending[d]) begin
          chk($sformatf("hold_valid_dut%0d", d), 33'(resp_valid[d]), 33'd1);
          chk($sformatf("hold_data_dut%0d", d), got, hold_val[d]);
        end
        hold_pending[d] = resp_valid[d] && !resp_ready[d] && !rst;
        hold_val[d] = got;
        if (resp_valid[d] && resp_ready[d]) on_fire(d, got);
      end
    end
  end

  task automatic do_req(input int d, input logic [31:0] a, input logic [32:0] e,
                        output int stall, output int acc);
    stall = 0;
    req_valid[d] = 1'b1;
    req_addr[d] = a;
    while (!req_ready[d] && stall < 50) begin
      @(posedge clk); #1;
      stall++;
    end
    if (!req_ready[d]) begin
      chki($sformatf("req_accept_timeout_dut%0d", d), 0, 1);
    end else begin
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    @(posedge clk); #1;
    acc = cyc;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int g;
    g = 0;
    while (qsize(d) != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chki($sformatf("drain_dut%0d", d), qsize(d), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int s, a0, a1, nf;
    int stalls [4];
    logic [31:0] pre_addr [5];
    logic [31:0] pre_data [5];
    pre_addr = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd255};
    pre_data = '{W0[31:0], W1[31:0], W2[31:0], W3[31:0], WL[31:0]};
    rst = 1'b1;
    load_we = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_addr[d] = '0;
      resp_ready[d] = 1'b1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      load_we = 1'b1;
      load_addr = pre_addr[i][7:0];
      load_data = pre_data[i];
      @(posedge clk); #1;
    end
    load_we = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_req_ready_dut%0d", d), 33'(req_ready[d]), 33'd0);
      chk($sformatf("rst_resp_valid_dut%0d", d), 33'(resp_valid[d]), 33'd0);
      chk($sformatf("rst_resp_data_dut%0d", d), 33'(resp_data[d]), 33'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk($sformatf("post_rst_ready_dut%0d", d), 33'(req_ready[d]), 33'd1);

    // LATENCY 1, back-to-back fetches at full rate
    nf = n_fire[0];
    do_req(0, 32'h0, W0, stalls[0], a0);
    do_req(0, 32'h4, W1, stalls[1], s);
    do_req(0, 32'h8, W2, stalls[2], s);
    do_req(0, 32'hC, W3, stalls[3], s);
    for (int i = 0; i < 4; i++) chki($sformatf("b2b_stall%0d", i), stalls[i], 0);
    drain(0);
    chki("b2b_count", n_fire[0] - nf, 4);
    chki("b2b_last_cycle", last_fire[0], a0 + 3);

    // Backpressure: head held for 5 cycles, count saturates
    resp_ready[0] = 1'b0;
    do_req(0, 32'h0, W0, s, a0);
    do_req(0, 32'h4, W1, s, a0);
    chk("bp_ready_low", 33'(req_ready[0]), 33'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), 33'(resp_valid[0]), 33'd1);
      chk($sformatf("bp_data%0d", i), 33'(resp_data[0]), W0);
      @(posedge clk); #1;
    end
    resp_ready[0] = 1'b1;
    do_req(0, 32'h8, W2, s, a0);
    chki("bp_release_stall", s, 1);
    drain(0);

    // LATENCY 3 with continuous request pressure
    nf = n_fire[1];
    do_req(1, 32'h0, W0, s, a0);
    do_req(1, 32'h4, W1, s, a1);
    chk("lat3_not_early", 33'(resp_valid[1]), 33'd0);
    chki("lat3_no_fire_yet", n_fire[1] - nf, 0);
    do_req(1, 32'h8, W2, s, a1);
    chki("lat3_ready_gap", s, 2);
    chki("lat3_fires_mid", n_fire[1] - nf, 2);
    chki("lat3_second_fire", last_fire[1], a0 + 3);
    do_req(1, 32'hC, W3, s, a1);
    drain(1);
    chki("lat3_total", n_fire[1] - nf, 4);

    // Load and fetch of the same word in one cycle: old data returned
    load_we = 1'b1;
    load_addr = 8'd2;
    load_data = WD[31:0];
    do_req(0, 32'h8, W2, s, a0);
    load_we = 1'b0;
    do_req(0, 32'h8, WD, s, a0);
    drain(0);

    // Address boundaries
    do_req(0, 32'h3FC, WL, s, a0);
    do_req(0, 32'h400, E_OOR, s, a0);
    do_req(0, 32'h6, E_MIS, s, a0);
    do_req(0, 32'hFFFFFFFC, E_OOR, s, a0);
    drain(0);

    // Reset with two responses in flight: they must never appear
    nf = n_fire[1];
    do_req(1, 32'h0, W0, s, a0);
    do_req(1, 32'h4, W1, s, a0);
    rst = 1'b1;
    exp_q1.delete();
    @(posedge clk); #1;
    chk("midrst_valid", 33'(resp_valid[1]), 33'd0);
    chk("midrst_ready", 33'(req_ready[1]), 33'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_release_ready", 33'(req_ready[1]), 33'd1);
    repeat (12) @(posedge clk);
    #1;
    chki("midrst_no_stale", n_fire[1] - nf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
